dcache_wshr_merge: RTL and testbench
====================================

DCACHE_WSHR_MERGE -- requirements
Module: dcache_wshr_merge

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of WSHR entries; any value >= 2.
REQ-002 SHALL have parameter ADDR_W, default 26: block-address width (set index plus tag bits).
REQ-003 SHALL have parameter CNT_W, default 2: per-entry outstanding-write counter width; CMAX = 2^CNT_W-1.
REQ-004 SHALL have derived parameter IDX_W = $clog2(DEPTH).
REQ-005 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port: pushReq_valid_i  in  1  write-miss push request.
REQ-008 SHALL have port: pushReq_ready_o  out  1  push accepted when valid&ready.
REQ-009 SHALL have port: pushReq_blockAddr_i  in  ADDR_W  block address of push.
REQ-010 SHALL have port: conflict_o  out  1  valid entry matches pushReq_blockAddr_i.
REQ-011 SHALL have port: merged_o  out  1  accepted push merged into an existing entry.
REQ-012 SHALL have port: pushedIdx_o  out  IDX_W  entry index used by the accepted push.
REQ-013 SHALL have port: popReq_valid_i  in  1  one write acknowledge returned.
REQ-014 SHALL have port: popReq_bits_i  in  IDX_W  entry index acknowledged.
REQ-015 SHALL have port: pop_err_o  out  1  registered pulse: pop to an invalid entry.
REQ-016 SHALL have ports: empty_o  out  1  no valid entry; full_o  out  1  all entries valid.
REQ-017 SHALL have ports: invflu_valid_i  in  1  invalidate/flush drain request; invflu_ready_o  out  1  request accepted.
REQ-018 SHALL have port: invflu_done_o  out  1  registered one-cycle pulse: drain complete.

Function
REQ-019 Each entry SHALL hold valid, blockAddr[ADDR_W] and cnt[CNT_W]; valid implies cnt >= 1.
REQ-020 match[i] SHALL be valid[i] && blockAddr[i]==pushReq_blockAddr_i, from current-cycle state only; conflict_o = |match, independent of pushReq_valid_i.
REQ-021 At most one entry SHALL match; a hit entry's index is the merge target.
REQ-022 Merge case (conflict_o=1): pushReq_ready_o = (cnt[hit]<CMAX || pop to hit this cycle) && drain FSM in IDLE; accepted push increments cnt[hit]; merged_o=1; pushedIdx_o=hit.
REQ-023 Allocate case (conflict_o=0): pushReq_ready_o = (!full_o || popReq_valid_i freeing an entry this cycle) && FSM in IDLE; target = lowest-index free entry, or the freed entry when full; set valid=1, cnt=1, blockAddr; merged_o=0.
REQ-024 pushedIdx_o and merged_o SHALL be combinational, valid in the push handshake cycle; don't-care otherwise.
REQ-025 Pop to valid entry SHALL decrement cnt; when cnt==1 the entry SHALL clear valid (cnt=0).
REQ-026 Same-cycle merge push and pop on the same entry SHALL leave cnt unchanged and the entry valid, including cnt==1.
REQ-027 Same-cycle pop freeing entry k and allocate push SHALL reuse k only when no other free entry exists; else the lowest free entry is used and k is freed.
REQ-028 Pop to an invalid entry SHALL change no state and assert pop_err_o the next cycle for one cycle.
REQ-029 Drain FSM SHALL have states IDLE, DRAIN, DONE; invflu_ready_o=1 only in IDLE.
REQ-030 IDLE->DRAIN on invflu_valid_i; DRAIN->DONE when empty_o; DONE->IDLE unconditionally, invflu_done_o=1 in DONE only.
REQ-031 If empty_o at acceptance, DONE SHALL be reached the next cycle (done pulse 2 cycles after request edge).
REQ-032 In DRAIN and DONE pushReq_ready_o SHALL be 0; pops continue.
REQ-033 empty_o/full_o SHALL be combinational from registered valid bits.

Reset
REQ-034 On rst_n low, immediately and regardless of clock: all valid=0, cnt=0, blockAddr=0, FSM=IDLE.
REQ-035 Reset output values: pushReq_ready_o=1, empty_o=1, full_o=0, conflict_o=0, pop_err_o=0, invflu_ready_o=1, invflu_done_o=0.
REQ-036 Reset asserted mid-drain SHALL abandon the drain with no done pulse.

Verification
REQ-037 Push 0x100, 0x200, 0x300, 0x400 (DEPTH=4) -> pushedIdx 0,1,2,3; full_o=1, pushReq_ready_o=0 for 0x500.
REQ-038 Push 0x100 four times (CMAX=3) -> idx 0, merged_o=0,1,1; fourth stalled until pop idx0, then accepted same cycle, cnt stays 3.
REQ-039 Full queue, push 0x500 with pop idx2 (cnt=1) same cycle -> accepted, pushedIdx=2, full_o stays 1.
REQ-040 Entry0 cnt=1, push 0x100 with pop idx0 same cycle -> entry0 valid, cnt=1, merged_o=1.
REQ-041 Two valid entries, invflu_valid_i -> pushes blocked; pop both; invflu_done_o pulses one cycle after empty_o rises; pop idx3 while invalid -> pop_err_o next cycle.

Source files
------------

// File: rtl/dcache_wshr_merge.sv
// Write-status holding registers for the data cache: tracks outstanding write-miss blocks,
// merges repeat writes to the same block and drains all entries on invalidate/flush.
module dcache_wshr_merge #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned CNT_W  = 2,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pushReq_valid_i,
  output logic              pushReq_ready_o,
  input  logic [ADDR_W-1:0] pushReq_blockAddr_i,
  output logic              conflict_o,
  output logic              merged_o,
  output logic [IDX_W-1:0]  pushedIdx_o,
  input  logic              popReq_valid_i,
  input  logic [IDX_W-1:0]  popReq_bits_i,
  output logic              pop_err_o,
  output logic              empty_o,
  output logic              full_o,
  input  logic              invflu_valid_i,
  output logic              invflu_ready_o,
  output logic              invflu_done_o
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] blockAddr_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q [DEPTH];
  state_e            state_q;
  logic              popErr_q;

  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] popSel;
  logic [DEPTH-1:0] pushSel;
  logic [IDX_W-1:0] hitIdx;
  logic [IDX_W-1:0] freeIdx;
  logic [CNT_W-1:0] hitCnt;
  logic [CNT_W-1:0] popCnt;
  logic             anyFree;
  logic             popValidEntry;
  logic             popHit;
  logic             popFree;
  logic             idle;
  logic             pushFire;

  always_comb begin
    match         = '0;
    hitIdx        = '0;
    hitCnt        = '0;
    popCnt        = '0;
    popValidEntry = 1'b0;
    freeIdx       = '0;
    anyFree       = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      match[i] = valid_q[i] && (blockAddr_q[i] == pushReq_blockAddr_i);
      if (match[i]) begin
        hitIdx = IDX_W'(i);
        hitCnt = cnt_q[i];
      end
      if (popReq_bits_i == IDX_W'(i)) begin
        popCnt        = cnt_q[i];
        popValidEntry = valid_q[i];
      end
    end
    // Scan downwards so the lowest free index wins.
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        freeIdx = IDX_W'(i);
        anyFree = 1'b1;
      end
    end
  end

  assign idle       = (state_q == StIdle);
  assign popHit     = popReq_valid_i && popValidEntry;
  assign popFree    = popHit && (popCnt == CNT_ONE);
  assign conflict_o = |match;
  assign merged_o   = conflict_o;
  assign empty_o    = ~|valid_q;
  assign full_o     = &valid_q;

  // A saturated entry can still absorb a merge when the same entry is popped this cycle.
  assign pushReq_ready_o = idle && (conflict_o
                           ? ((hitCnt != CMAX) || (popHit && (popReq_bits_i == hitIdx)))
                           : (anyFree || popFree));
  assign pushedIdx_o = conflict_o ? hitIdx : (anyFree ? freeIdx : popReq_bits_i);
  assign pushFire    = pushReq_valid_i && pushReq_ready_o;

  always_comb begin
    popSel  = '0;
    pushSel = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      popSel[i]  = popHit && (popReq_bits_i == IDX_W'(i));
      pushSel[i] = pushFire && (pushedIdx_o == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        blockAddr_q[i] <= '0;
        cnt_q[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (pushSel[i] && merged_o) begin
          if (!popSel[i]) cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end else if (pushSel[i]) begin
          // Also covers reuse of an entry freed by a same-cycle pop.
          valid_q[i]     <= 1'b1;
          cnt_q[i]       <= CNT_ONE;
          blockAddr_q[i] <= pushReq_blockAddr_i;
        end else if (popSel[i]) begin
          cnt_q[i] <= cnt_q[i] - CNT_ONE;
          if (cnt_q[i] == CNT_ONE) valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      popErr_q <= 1'b0;
    end else begin
      popErr_q <= popReq_valid_i && !popValidEntry;
      unique case (state_q)
        StIdle:  if (invflu_valid_i) state_q <= StDrain;
        StDrain: if (empty_o) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pop_err_o      = popErr_q;
  assign invflu_ready_o = idle;
  assign invflu_done_o  = (state_q == StDone);

endmodule

// File: tb/tb_dcache_wshr_merge.sv
// Scoreboard bench: a per-entry reference model predicts each cycle's outputs, a monitor
// process compares them mid-cycle against the DUT.
module tb_dcache_wshr_merge;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 26;
  localparam int CNT_W  = 2;
  localparam int IDX_W  = 2;
  localparam int CMAX   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pushReq_valid_i = 1'b0;
  logic              pushReq_ready_o;
  logic [ADDR_W-1:0] pushReq_blockAddr_i = '0;
  logic              conflict_o;
  logic              merged_o;
  logic [IDX_W-1:0]  pushedIdx_o;
  logic              popReq_valid_i = 1'b0;
  logic [IDX_W-1:0]  popReq_bits_i = '0;
  logic              pop_err_o;
  logic              empty_o;
  logic              full_o;
  logic              invflu_valid_i = 1'b0;
  logic              invflu_ready_o;
  logic              invflu_done_o;

  always #5 clk = ~clk;

  dcache_wshr_merge #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pushReq_valid_i     (pushReq_valid_i),
    .pushReq_ready_o     (pushReq_ready_o),
    .pushReq_blockAddr_i (pushReq_blockAddr_i),
    .conflict_o          (conflict_o),
    .merged_o            (merged_o),
    .pushedIdx_o         (pushedIdx_o),
    .popReq_valid_i      (popReq_valid_i),
    .popReq_bits_i       (popReq_bits_i),
    .pop_err_o           (pop_err_o),
    .empty_o             (empty_o),
    .full_o              (full_o),
    .invflu_valid_i      (invflu_valid_i),
    .invflu_ready_o      (invflu_ready_o),
    .invflu_done_o       (invflu_done_o)
  );

  typedef struct {
    bit ready, conflict, merged, empty, full, err, invReady, done, hs;
    int idx;
  } exp_t;

  exp_t q[$];
  int   nChecks = 0;
  int   nFail = 0;

  // Reference model: one record per entry plus drain phase (0 idle, 1 drain, 2 done).
  bit mValid [DEPTH];
  int mAddr  [DEPTH];
  int mCnt   [DEPTH];
  int mState;
  bit mErr;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pushReq_ready", int'(pushReq_ready_o), int'(e.ready));
      chk("conflict", int'(conflict_o), int'(e.conflict));
      chk("empty", int'(empty_o), int'(e.empty));
      chk("full", int'(full_o), int'(e.full));
      chk("pop_err", int'(pop_err_o), int'(e.err));
      chk("invflu_ready", int'(invflu_ready_o), int'(e.invReady));
      chk("invflu_done", int'(invflu_done_o), int'(e.done));
      if (e.hs) begin
        chk("merged", int'(merged_o), int'(e.merged));
        chk("pushedIdx", int'(pushedIdx_o), e.idx);
      end
    end
  end

  function automatic int mCount();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(mValid[i]);
    return n;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      mValid[i] = 0;
      mAddr[i]  = 0;
      mCnt[i]   = 0;
    end
    mState = 0;
    mErr   = 0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs checked while it is held.
  task automatic doReset();
    exp_t e;
    @(negedge clk);
    pushReq_valid_i = 0;
    popReq_valid_i  = 0;
    invflu_valid_i  = 0;
    #1;
    rst_n = 0;
    modelReset();
    e = '{ready: 1, conflict: 0, merged: 0, empty: 1, full: 0, err: 0, invReady: 1,
           done: 0, hs: 0, idx: 0};
    q.push_back(e);
    #2;
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic cycle(input bit pv, input int addr, input bit popv, input int pidx,
                       input bit inv);
    exp_t e;
    int   hit, lowest, n;
    bit   popOk, willFree, idle, wasEmpty;
    @(negedge clk);
    pushReq_valid_i     = pv;
    pushReq_blockAddr_i = addr[ADDR_W-1:0];
    popReq_valid_i      = popv;
    popReq_bits_i       = pidx[IDX_W-1:0];
    invflu_valid_i      = inv;
    #1;
    hit = -1;
    lowest = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (mValid[i] && mAddr[i] == addr) hit = i;
      if (!mValid[i] && lowest < 0) lowest = i;
    end
    popOk    = popv && mValid[pidx];
    willFree = popOk && mCnt[pidx] == 1;
    idle     = (mState == 0);
    n        = mCount();
    e.conflict = (hit >= 0);
    if (hit >= 0) begin
      e.ready  = idle && (mCnt[hit] < CMAX || (popOk && pidx == hit));
      e.merged = 1;
      e.idx    = hit;
    end else begin
      e.ready  = idle && (lowest >= 0 || willFree);
      e.merged = 0;
      e.idx    = (lowest >= 0) ? lowest : pidx;
    end
    e.empty    = (n == 0);
    e.full     = (n == DEPTH);
    e.err      = mErr;
    e.invReady = idle;
    e.done     = (mState == 2);
    e.hs       = pv && e.ready;
    q.push_back(e);

    wasEmpty = e.empty;
    mErr = popv && !mValid[pidx];
    if (popOk) begin
      mCnt[pidx]--;
      if (mCnt[pidx] == 0) mValid[pidx] = 0;
    end
    if (e.hs) begin
      if (hit >= 0) begin
        mCnt[hit]++;
        mValid[hit] = 1;
      end else begin
        mValid[e.idx] = 1;
        mCnt[e.idx]   = 1;
        mAddr[e.idx]  = addr;
      end
    end
    case (mState)
      0: if (inv) mState = 1;
      1: if (wasEmpty) mState = 2;
      default: mState = 0;
    endcase
  endtask

  initial begin
    modelReset();
    doReset();

    // Fill all four entries, then a fifth block stalls; popping a cnt=1 entry frees it.
    cycle(1, 'h100, 0, 0, 0);
    cycle(1, 'h200, 0, 0, 0);
    cycle(1, 'h300, 0, 0, 0);
    cycle(1, 'h400, 0, 0, 0);
    cycle(1, 'h500, 0, 0, 0);
    cycle(1, 'h500, 1, 2, 0);
    cycle(0, 'h500, 0, 0, 0);

    // Counter saturation and merge with same-cycle pop.
    doReset();
    for (int i = 0; i < 4; i++) cycle(1, 'h100, 0, 0, 0);
    cycle(1, 'h100, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 'h100, 1, 0, 0);

    // Merge onto a cnt=1 entry while it is popped keeps it alive.
    doReset();
    cycle(1, 'h100, 0, 0, 0);
    cycle(1, 'h100, 1, 0, 0);
    cycle(0, 'h100, 1, 0, 0);
    cycle(0, 'h100, 0, 0, 0);

    // Drain with two entries, then a pop to an invalid entry.
    doReset();
    cycle(1, 'h100, 0, 0, 0);
    cycle(1, 'h200, 0, 0, 0);
    cycle(0, 'h0, 0, 0, 1);
    cycle(1, 'h300, 1, 0, 0);
    cycle(1, 'h300, 1, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 'h0, 0, 0, 0);
    cycle(0, 'h0, 1, 3, 0);
    cycle(0, 'h0, 0, 0, 0);
    cycle(0, 'h0, 0, 0, 0);

    // Drain on an already-empty cache.
    cycle(0, 'h0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 'h0, 0, 0, 0);

    // Reset in the middle of a drain must not produce a done pulse.
    cycle(1, 'h100, 0, 0, 0);
    cycle(0, 'h0, 0, 0, 1);
    cycle(0, 'h0, 0, 0, 0);
    doReset();
    for (int i = 0; i < 3; i++) cycle(0, 'h100, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) doReset();
      cycle($urandom_range(0, 3) != 0, 'h100 * int'($urandom_range(1, 6)),
            $urandom_range(0, 2) == 0, int'($urandom_range(0, DEPTH - 1)),
            $urandom_range(0, 40) == 0);
    end

    cycle(0, 'h0, 0, 0, 0);
    @(negedge clk);
    #3;
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
